vga_scan_overlay: RTL
=====================

VGA_SCAN_OVERLAY -- requirements
Module: vga_scan_overlay

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_ACTIVE 640 visible pixels/line; H_FP 16; H_SYNC 96; H_BP 48; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; SYNC_POL 0 (sync asserted level); PIPE 2 (pixEn ticks of downstream RGB latency, 1..4); NCUR 2 (cursor channels, 1..4); CUR_SIZE 8 (cursor square edge, pixels); COORD_W 11.
REQ-002 SHALL have ports (name, direction, width, meaning), clock and reset first: CLOCK in 1 system clock; RESET in 1 reset; pixEn in 1 pixel-rate tick; rgbIn in 24 {r,g,b} for the coordinate issued PIPE ticks earlier; curX in NCUR*COORD_W cursor left edges, channel i at bits [i*COORD_W +: COORD_W]; curY in NCUR*COORD_W cursor top edges; curColor in NCUR*24 cursor colours; curEn in NCUR cursor enables; xPixel out COORD_W; yPixel out COORD_W; hsync out 1; vsync out 1; VGAblanck out 1 (active-low blank); VGAr out 8; VGAg out 8; VGAb out 8; frameStart out 1 one-CLOCK pulse.
REQ-003 SHALL use one clock, CLOCK; RESET SHALL be synchronous and active-high.

Function
REQ-004 SHALL keep hCnt 0..H_TOTAL-1 (H_TOTAL = sum of H_* parameters) and vCnt 0..V_TOTAL-1, with state changing only on CLOCK edges where pixEn=1.
REQ-005 On pixEn, hCnt SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vCnt SHALL increment, with vCnt wrapping to 0 after V_TOTAL-1.
REQ-006 xPixel/yPixel SHALL equal hCnt/vCnt while both are in the active region, else 0.
REQ-007 Stage-0 raw hsync SHALL be asserted (=SYNC_POL) for hCnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; raw vsync likewise in vCnt.
REQ-008 Stage-0 active = (hCnt<H_ACTIVE)&&(vCnt<V_ACTIVE).
REQ-009 Raw sync, active and coordinates SHALL pass through a PIPE-deep shift register advanced only on pixEn, so hsync, vsync, VGAblanck and overlay decisions align with rgbIn.
REQ-010 Cursor inputs SHALL be latched into shadow registers only on the pixEn tick where hCnt=0 and vCnt=0; input changes mid-frame SHALL have no effect until the next frame.
REQ-011 frameStart SHALL pulse high for exactly one CLOCK on the same edge as the REQ-010 latch.
REQ-012 Cursor i SHALL hit when latched enable=1, delayed x in [curX_i, curX_i+CUR_SIZE-1] and delayed y in [curY_i, curY_i+CUR_SIZE-1]; sums SHALL be computed at COORD_W+1 bits with no wrap, so cursors near the edge clip instead of wrapping to the opposite side.
REQ-013 With multiple hits, the lowest channel index SHALL win.
REQ-014 Output colour, registered on pixEn: if delayed active=0, RGB=0; else if any hit, winning curColor; else rgbIn.
REQ-015 VGAblanck SHALL equal delayed active; hsync/vsync SHALL be registered in the same stage as RGB.
REQ-016 Outputs SHALL hold their value between pixEn ticks; pixEn held high constantly SHALL be legal.

Reset
REQ-017 When RESET=1 on a CLOCK edge, regardless of pixEn: hCnt=vCnt=0; pipeline cleared to inactive/unasserted; shadow enables=0; xPixel=yPixel=0; hsync=vsync=!SYNC_POL; VGAblanck=0; RGB=0; frameStart=0.
REQ-018 After RESET deasserts, the first pixEn tick SHALL be treated as hCnt=0, vCnt=0 (latch and frameStart per REQ-010/011); RESET mid-frame SHALL abort the frame with no partial sync pulse held.

Verification
REQ-019 Defaults, pixEn every 2nd CLOCK, one full frame -> 800 ticks/line, 525 lines; hsync low for ticks 656..751; vsync low for lines 490..491; frameStart once per 420000 ticks.
REQ-020 PIPE=2, rgbIn=f(coordinate) from model, no cursors -> VGAr/g/b at output equals f(x,y) for every active pixel; 0 during blanking.
REQ-021 NCUR=2, cursor0 (100,100) red, cursor1 (104,104) blue, both enabled -> (104..107,104..107) red; (108..111,108..111) blue; (100,100) red.
REQ-022 Cursor0 at (636,476), CUR_SIZE=8 -> overlay only on x 636..639, y 476..479; no colour at x=0..3 or y=0..3.
REQ-023 Move curX mid-frame -> no change until after next frameStart; next frame shows new position.
REQ-024 Assert RESET at hCnt=700 during the hsync window -> next edge hsync=1, VGAblanck=0, RGB=0; restart at (0,0) with frameStart on the first pixEn.

Source files
------------

// File: rtl/vga_scan_overlay.sv
// vga_scan_overlay
//   VGA timing generator with a PIPE-deep alignment pipeline and NCUR
//   square cursor overlays. The counters issue a pixel coordinate on
//   xPixel/yPixel. The downstream renderer returns that pixel's colour on
//   rgbIn PIPE pixEn ticks later. Sync, blanking and the cursor overlay
//   are delayed by the same amount, so they line up with rgbIn.
//
// Ports
//   CLOCK      system clock; every register runs on its rising edge
//   RESET      synchronous, active-high
//   pixEn      pixel-rate tick; all scan state advances only when it is 1
//   rgbIn      {r,g,b} for the coordinate issued PIPE ticks earlier
//   curX/curY  per-channel cursor left/top edge, channel i at [i*COORD_W +: COORD_W]
//   curColor   per-channel cursor colour, channel i at [i*24 +: 24]
//   curEn      per-channel cursor enable
//   xPixel/yPixel  coordinate being issued (0 outside the visible area)
//   hsync/vsync    sync outputs, asserted level SYNC_POL
//   VGAblanck      active-low blank (1 while visible)
//   VGAr/g/b       output colour
//   frameStart     one-CLOCK pulse when a new frame starts and cursors are latched
module vga_scan_overlay #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int PIPE     = 2,
    parameter int NCUR     = 2,
    parameter int CUR_SIZE = 8,
    parameter int COORD_W  = 11
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic                      pixEn,
    input  logic [23:0]               rgbIn,
    input  logic [NCUR*COORD_W-1:0]   curX,
    input  logic [NCUR*COORD_W-1:0]   curY,
    input  logic [NCUR*24-1:0]        curColor,
    input  logic [NCUR-1:0]           curEn,
    output logic [COORD_W-1:0]        xPixel,
    output logic [COORD_W-1:0]        yPixel,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      VGAblanck,
    output logic [7:0]                VGAr,
    output logic [7:0]                VGAg,
    output logic [7:0]                VGAb,
    output logic                      frameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEGIN = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEGIN = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COORD_W:0]   CUR_EXT  = (COORD_W+1)'(CUR_SIZE);
    localparam logic               SYNC_ON  = (SYNC_POL != 0);

    // The sync flags mean "asserted", independent of polarity. A cleared stage
    // is therefore inactive and unasserted whatever SYNC_POL is.
    typedef struct packed {
        logic               active;
        logic               hs_on;
        logic               vs_on;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } stage_t;

    logic [COORD_W-1:0] h_cnt, v_cnt;
    logic               active0, frame_tick;
    stage_t             stage0, dly;
    stage_t             pipe [PIPE];

    logic [COORD_W-1:0] sh_x [NCUR];
    logic [COORD_W-1:0] sh_y [NCUR];
    logic [23:0]        sh_c [NCUR];
    logic [NCUR-1:0]    sh_en;

    logic               hit;
    logic [23:0]        hit_color;

    // ---------------- scan counters ----------------
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pixEn) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign active0    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign frame_tick = pixEn && (h_cnt == '0) && (v_cnt == '0);
    assign xPixel     = active0 ? h_cnt : '0;
    assign yPixel     = active0 ? v_cnt : '0;

    assign stage0.active = active0;
    assign stage0.hs_on  = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
    assign stage0.vs_on  = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
    assign stage0.x      = xPixel;
    assign stage0.y      = yPixel;

    // ---------------- alignment pipeline ----------------
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < PIPE; i++) pipe[i] <= '0;
        end else if (pixEn) begin
            pipe[0] <= stage0;
            for (int i = 1; i < PIPE; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dly = pipe[PIPE-1];

    // ---------------- cursor shadows ----------------
    // Cursor inputs are sampled only at the first pixel of a frame. Inputs that
    // change mid-frame therefore cannot tear a cursor.
    // NOTE: position/colour shadows have no reset; they are ignored until the reset-cleared enable is set.
    always_ff @(posedge CLOCK) begin
        if (frame_tick && !RESET) begin
            for (int i = 0; i < NCUR; i++) begin
                sh_x[i] <= curX[i*COORD_W +: COORD_W];
                sh_y[i] <= curY[i*COORD_W +: COORD_W];
                sh_c[i] <= curColor[i*24 +: 24];
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET)           sh_en <= '0;
        else if (frame_tick) sh_en <= curEn;
    end

    // ---------------- hit test ----------------
    // Range ends use one extra bit, so a cursor near the right or bottom
    // edge is clipped instead of wrapping to coordinate 0. The loop runs from
    // the highest channel down, so the lowest hitting channel is written last and wins.
    // NOTE: outputs get defaults before the loop so no path leaves them unassigned (no latch).
    always_comb begin
        hit       = 1'b0;
        hit_color = '0;
        for (int i = NCUR - 1; i >= 0; i--) begin
            if (sh_en[i]
                && ({1'b0, dly.x} >= {1'b0, sh_x[i]}) && ({1'b0, dly.x} < {1'b0, sh_x[i]} + CUR_EXT)
                && ({1'b0, dly.y} >= {1'b0, sh_y[i]}) && ({1'b0, dly.y} < {1'b0, sh_y[i]} + CUR_EXT)) begin
                hit       = 1'b1;
                hit_color = sh_c[i];
            end
        end
    end

    // ---------------- output stage ----------------
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            hsync              <= ~SYNC_ON;
            vsync              <= ~SYNC_ON;
            VGAblanck          <= 1'b0;
            {VGAr, VGAg, VGAb} <= '0;
            frameStart         <= 1'b0;
        end else begin
            frameStart <= frame_tick;
            if (pixEn) begin
                hsync     <= dly.hs_on ? SYNC_ON : ~SYNC_ON;
                vsync     <= dly.vs_on ? SYNC_ON : ~SYNC_ON;
                VGAblanck <= dly.active;
                if (!dly.active) {VGAr, VGAg, VGAb} <= '0;
                else if (hit)    {VGAr, VGAg, VGAb} <= hit_color;
                else             {VGAr, VGAg, VGAb} <= rgbIn;
            end
        end
    end

endmodule
